// File: rtl/pipe_stage_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_chain: DEPTH-deep register chain with valid/ready, flush,        |
// | occupancy and a saturating flush counter.  Rev 1.0                          |
// +----------------------------------------------------------------------------+
module pipe_stage_chain #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 3,
  parameter int COUNT_W = 16,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [DEPTH-1:0]   flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [OCC_W-1:0]   occupancy,
  output logic [COUNT_W-1:0] flushed_count
);

  localparam int SUM_W = ((COUNT_W > OCC_W) ? COUNT_W : OCC_W) + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic [COUNT_W-1:0]          fc_q, fc_d;
  logic [DEPTH-1:0]            live;
  logic [DEPTH-1:0]            adv;
  logic [SUM_W-1:0]            kill_sum;
  logic [SUM_W-1:0]            fc_sum;
  logic                        rdy;

  // Ready ripples from the consumer back toward the producer within one cycle.
  always_comb begin
    live = v_q & ~flush;
    adv  = '0;
    rdy  = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = ~v_q[i] | flush[i] | rdy;
      rdy    = adv[i];
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv[0]) begin
      v_d[0] = in_valid;
      d_d[0] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i]) begin
        v_d[i] = live[i-1];
        d_d[i] = d_q[i-1];
      end
    end

    occ_d    = '0;
    kill_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d    = occ_d + OCC_W'(v_d[i]);
      kill_sum = kill_sum + SUM_W'(v_q[i] & flush[i]);
    end

    fc_sum = SUM_W'(fc_q) + kill_sum;
    fc_d   = (fc_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : fc_sum[COUNT_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      d_q   <= '0;
      occ_q <= '0;
      fc_q  <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
      fc_q  <= fc_d;
    end
  end

  assign in_ready      = adv[0];
  assign out_valid     = live[DEPTH-1];
  assign out_data      = d_q[DEPTH-1];
  assign occupancy     = occ_q;
  assign flushed_count = fc_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_stage_chain: directed vector bench for pipe_stage_chain            |
// | (DEPTH=3, WIDTH=32, COUNT_W=4).  Rev 1.0                                    |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_chain;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 3;
  localparam int COUNT_W = 4;
  localparam int OCC_W   = $clog2(DEPTH + 1);

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [DEPTH-1:0]   flush;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [OCC_W-1:0]   occupancy;
  logic [COUNT_W-1:0] flushed_count;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .occupancy     (occupancy),
    .flushed_count (flushed_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [2:0]  fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_occ;
    int          e_fc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [31:0] d, input logic [2:0] fl,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [31:0] e_od, input int e_occ, input int e_fc);
    vec_t v;
    v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_fc = e_fc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector shortly after a rising edge, check pre-edge outputs, then clock.
  task automatic apply(input int idx, input string tag);
    vec_t v;
    v = vecs[idx];
    in_valid  = v.iv;
    in_data   = v.d;
    flush     = v.fl;
    out_ready = v.ordy;
    #1;
    chk($sformatf("%s[%0d] in_ready", tag, idx), {31'b0, in_ready}, {31'b0, v.e_ir});
    chk($sformatf("%s[%0d] out_valid", tag, idx), {31'b0, out_valid}, {31'b0, v.e_ov});
    if (v.e_ov)
      chk($sformatf("%s[%0d] out_data", tag, idx), out_data, v.e_od);
    chk($sformatf("%s[%0d] occupancy", tag, idx), 32'(occupancy), 32'(v.e_occ));
    chk($sformatf("%s[%0d] flushed_count", tag, idx), 32'(flushed_count), 32'(v.e_fc));
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Rows 0-6: unstalled stream of 1,2,3
    add(1, 32'h1, 3'b000, 1, 1, 0, 32'h0, 0, 0);
    add(1, 32'h2, 3'b000, 1, 1, 0, 32'h0, 1, 0);
    add(1, 32'h3, 3'b000, 1, 1, 0, 32'h0, 2, 0);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'h1, 3, 0);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'h2, 2, 0);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'h3, 1, 0);
    add(0, 32'h0, 3'b000, 0, 1, 0, 32'h0, 0, 0);
    // Rows 7-15: backpressure, four words offered, then drain in order
    add(1, 32'h21, 3'b000, 0, 1, 0, 32'h0, 0, 0);
    add(1, 32'h22, 3'b000, 0, 1, 0, 32'h0, 1, 0);
    add(1, 32'h23, 3'b000, 0, 1, 0, 32'h0, 2, 0);
    add(1, 32'h24, 3'b000, 0, 0, 1, 32'h21, 3, 0);
    add(1, 32'h24, 3'b000, 0, 0, 1, 32'h21, 3, 0);
    add(1, 32'h24, 3'b000, 1, 1, 1, 32'h21, 3, 0);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'h22, 3, 0);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'h23, 2, 0);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'h24, 1, 0);
    // Rows 16-22: middle-stage flush under stall, refill from behind
    add(1, 32'hAAAA, 3'b000, 0, 1, 0, 32'h0, 0, 0);
    add(1, 32'hBBBB, 3'b000, 0, 1, 0, 32'h0, 1, 0);
    add(1, 32'hCCCC, 3'b000, 0, 1, 0, 32'h0, 2, 0);
    add(1, 32'hDDDD, 3'b010, 0, 1, 1, 32'hAAAA, 3, 0);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'hAAAA, 3, 1);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'hCCCC, 2, 1);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'hDDDD, 1, 1);
    // Rows 23-32: full flush with concurrent input, then empty flush
    add(1, 32'hE1, 3'b000, 0, 1, 0, 32'h0, 0, 1);
    add(1, 32'hE2, 3'b000, 0, 1, 0, 32'h0, 1, 1);
    add(1, 32'hE3, 3'b000, 0, 1, 0, 32'h0, 2, 1);
    add(1, 32'hBEEF, 3'b111, 0, 1, 0, 32'h0, 3, 1);
    add(0, 32'h0, 3'b000, 0, 1, 0, 32'h0, 1, 4);
    add(0, 32'h0, 3'b000, 1, 1, 0, 32'h0, 1, 4);
    add(0, 32'h0, 3'b000, 1, 1, 1, 32'hBEEF, 1, 4);
    add(0, 32'h0, 3'b000, 1, 1, 0, 32'h0, 0, 4);
    add(0, 32'h0, 3'b111, 1, 1, 0, 32'h0, 0, 4);
    add(0, 32'h0, 3'b000, 1, 1, 0, 32'h0, 0, 4);

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = '0;
    out_ready = 1'b0;
    #2;
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset occupancy", 32'(occupancy), 32'h0);
    chk("reset flushed_count", 32'(flushed_count), 32'h0);
    chk("reset in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      apply(i, "vec");

    // Asynchronous reset in the middle of a live stream
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = '0;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'h51 + 32'(k);
      @(posedge clock);
      #1;
    end
    #3;
    chk("pre-reset out_valid", {31'b0, out_valid}, 32'h1);
    chk("pre-reset out_data", out_data, 32'h51);
    chk("pre-reset flushed_count", 32'(flushed_count), 32'h4);
    reset = 1'b1;
    #1;
    chk("async reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("async reset occupancy", 32'(occupancy), 32'h0);
    chk("async reset flushed_count", 32'(flushed_count), 32'h0);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i <= 6; i++)
      apply(i, "post-reset");

    // Saturating flush counter: 20 single-entry kills
    out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k);
      flush    = 3'b000;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      flush    = 3'b001;
      @(posedge clock);
      #1;
      flush = 3'b000;
      #1;
      chk($sformatf("sat flushed_count k=%0d", k), 32'(flushed_count), (k < 15) ? 32'(k) : 32'd15);
    end
    flush = 3'b111;
    @(posedge clock);
    #1;
    flush = 3'b000;
    #1;
    chk("sat empty-flush flushed_count", 32'(flushed_count), 32'd15);
    chk("sat empty-flush occupancy", 32'(occupancy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
